// File: rtl/riscv_rf_sched.sv
// Register-file scheduler: scoreboard interlock, round-robin ALU/LSU writeback and operand issue.
// Optional same-cycle write forwarding is compiled in with RF_SCHED_BYPASS_EN.
module riscv_rf_sched #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dec_valid,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_wb,
  output logic            dec_ready,
  input  logic            alu_wvalid,
  input  logic [4:0]      alu_wrd,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_wready,
  input  logic            lsu_wvalid,
  input  logic [4:0]      lsu_wrd,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_wready,
  output logic            rf_cs,
  output logic            rf_wen,
  output logic [4:0]      rf_ra,
  output logic [4:0]      rf_rb,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] rf_a,
  input  logic [XLEN-1:0] rf_b,
  output logic            op_valid,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic [NREG-1:0] busy_q, busy_d;
  logic            ptr_q, ptr_d;       // 0: ALU has priority, 1: LSU
  logic            opv_q;
  logic            gnt_alu, gnt_lsu, gnt, gnt_nz;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic            fwd_rs1, fwd_rs2, fwd_rd;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            issue;

  // Round-robin writeback arbitration; nothing is granted while in reset
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    ptr_d   = ptr_q;
    if (rstn) begin
      if (alu_wvalid && lsu_wvalid) begin
        gnt_alu = !ptr_q;
        gnt_lsu = ptr_q;
        ptr_d   = !ptr_q;
      end else begin
        gnt_alu = alu_wvalid;
        gnt_lsu = lsu_wvalid;
      end
    end
  end

  assign gnt    = gnt_alu | gnt_lsu;
  assign g_rd   = gnt_lsu ? lsu_wrd : alu_wrd;
  assign g_data = gnt_lsu ? lsu_wdata : alu_wdata;
  assign gnt_nz = gnt && (g_rd != '0);

`ifdef RF_SCHED_BYPASS_EN
  assign fwd_rs1 = gnt_nz && (dec_rs1 == g_rd);
  assign fwd_rs2 = gnt_nz && (dec_rs2 == g_rd);
  assign fwd_rd  = gnt_nz && (dec_rd == g_rd);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
  assign fwd_rd  = 1'b0;
`endif

  assign rs1_busy  = busy_q[dec_rs1] & ~fwd_rs1;
  assign rs2_busy  = busy_q[dec_rs2] & ~fwd_rs2;
  assign rd_busy   = busy_q[dec_rd] & ~fwd_rd;
  assign dec_ready = !rs1_busy && !rs2_busy && !(dec_wb && rd_busy);
  assign issue     = rstn && dec_valid && dec_ready;

  assign alu_wready = gnt_alu;
  assign lsu_wready = gnt_lsu;
  assign rf_cs      = issue | gnt;
  assign rf_wen     = gnt_nz;
  assign rf_ra      = dec_rs1;
  assign rf_rb      = dec_rs2;
  assign rf_rd      = g_rd;
  assign rf_data    = g_data;
  assign op_valid   = opv_q;

  // Scoreboard update: writeback clears first so a same-cycle issue set wins
  always_comb begin
    busy_d = busy_q;
    if (gnt_nz) busy_d[g_rd] = 1'b0;
    if (issue && dec_wb && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      ptr_q  <= 1'b0;
      opv_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
      opv_q  <= issue;
    end
  end

`ifdef RF_SCHED_BYPASS_EN
  logic            sel_a_q, sel_b_q;
  logic [XLEN-1:0] byp_q;

  // Capture the forwarded write data alongside the issuing operand selects
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_a_q <= 1'b0;
      sel_b_q <= 1'b0;
      byp_q   <= '0;
    end else begin
      sel_a_q <= issue & fwd_rs1;
      sel_b_q <= issue & fwd_rs2;
      if (issue && (fwd_rs1 || fwd_rs2)) byp_q <= g_data;
    end
  end

  assign op_a = sel_a_q ? byp_q : rf_a;
  assign op_b = sel_b_q ? byp_q : rf_b;
`else
  assign op_a = rf_a;
  assign op_b = rf_b;
`endif

endmodule

// File: tb/tb_riscv_rf_sched.sv
// Self-checking bench for riscv_rf_sched with a behavioural register file and an operand scoreboard.
module tb_riscv_rf_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_valid, dec_wb, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        alu_wvalid, alu_wready, lsu_wvalid, lsu_wready;
  logic [4:0]  alu_wrd, lsu_wrd;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        rf_cs, rf_wen;
  logic [4:0]  rf_ra, rf_rb, rf_rd;
  logic [31:0] rf_data, rf_a, rf_b;
  logic        op_valid;
  logic [31:0] op_a, op_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];
  logic [31:0] ref_rf [32];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  riscv_rf_sched #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_wb(dec_wb), .dec_ready(dec_ready),
    .alu_wvalid(alu_wvalid), .alu_wrd(alu_wrd), .alu_wdata(alu_wdata), .alu_wready(alu_wready),
    .lsu_wvalid(lsu_wvalid), .lsu_wrd(lsu_wrd), .lsu_wdata(lsu_wdata), .lsu_wready(lsu_wready),
    .rf_cs(rf_cs), .rf_wen(rf_wen), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd(rf_rd),
    .rf_data(rf_data), .rf_a(rf_a), .rf_b(rf_b),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b)
  );

  // Behavioural register file: synchronous read, read-before-write
  always @(posedge clk) begin
    if (rf_cs) begin
      rf_a <= mem[rf_ra];
      rf_b <= mem[rf_rb];
      if (rf_wen) mem[rf_rd] <= rf_data;
    end
  end

  // Operand monitor: every op_valid pops one expected operand pair
  always @(negedge clk) begin
    logic [63:0] e;
    checks++;
    if (alu_wready && lsu_wready) begin
      errors++;
      $display("FAIL grant_exclusive alu_wready=%b lsu_wready=%b required at most one", alu_wready, lsu_wready);
    end
    if (op_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL op_unexpected op_a=%h op_b=%h with no issue pending", op_a, op_b);
      end else begin
        e = exp_q.pop_front();
        if ({op_a, op_b} !== e) begin
          errors++;
          $display("FAIL op_data got a=%h b=%h required a=%h b=%h", op_a, op_b, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wb);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wb = wb;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_wvalid = v; alu_wrd = rd; alu_wdata = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_wvalid = v; lsu_wrd = rd; lsu_wdata = d;
  endtask

  task automatic idle();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
  endtask

  task automatic push_op(input logic [4:0] rs1, input logic [4:0] rs2);
    exp_q.push_back({ref_rf[rs1], ref_rf[rs2]});
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_dec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
    set_alu(1'b1, 5'd4, 32'h1111_1111);
    set_lsu(1'b1, 5'd5, 32'h2222_2222);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rf_cs !== 1'b0) begin errors++; $display("FAIL reset_rf_cs got %b required 0", rf_cs); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b required 0", rf_wen); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b required 0", op_valid); end
    checks++; if ({alu_wready, lsu_wready} !== 2'b00) begin errors++; $display("FAIL reset_wready got %b required 00", {alu_wready, lsu_wready}); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready got %b required 1", dec_ready); end
    idle();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Issue a writer of x5 then a reader of x5 that must wait for the ALU writeback
  task automatic test_dependency();
    set_dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL dep_issue_rd5 got %b required 1", dec_ready); end
    push_op(5'd0, 5'd0);
    @(negedge clk);
    set_dec(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL dep_stall cycle %0d got %b required 0", i, dec_ready); end
      @(negedge clk);
    end
    set_alu(1'b1, 5'd5, 32'h5555_A5A5);
    #1;
    checks++; if ({alu_wready, lsu_wready} !== 2'b10) begin errors++; $display("FAIL dep_grant got %b required 10", {alu_wready, lsu_wready}); end
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5) begin errors++; $display("FAIL dep_write wen=%b rd=%0d required 1 5", rf_wen, rf_rd); end
    checks++; if (rf_data !== 32'h5555_A5A5) begin errors++; $display("FAIL dep_wdata got %h required 5555a5a5", rf_data); end
    ref_rf[5] = 32'h5555_A5A5;
`ifdef RF_SCHED_BYPASS_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL dep_bypass_ready got %b required 1", dec_ready); end
    push_op(5'd5, 5'd0);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL dep_grant_cycle_ready got %b required 0", dec_ready); end
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL dep_after_grant_ready got %b required 1", dec_ready); end
    push_op(5'd5, 5'd0);
    @(negedge clk);
`endif
    idle();
    repeat (2) @(negedge clk);
  endtask

  // Round-robin under continuous contention, then a lone LSU request leaves priority unchanged
  task automatic test_arbitration();
    logic exp_alu;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    set_alu(1'b1, 5'd10, 32'hA10A_0010);
    set_lsu(1'b1, 5'd11, 32'hB11B_0011);
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      #1;
      checks++;
      if ({alu_wready, lsu_wready} !== {exp_alu, !exp_alu}) begin
        errors++; $display("FAIL rr_grant cycle %0d got %b required %b", i, {alu_wready, lsu_wready}, {exp_alu, !exp_alu});
      end
      checks++;
      if (rf_rd !== (exp_alu ? 5'd10 : 5'd11)) begin
        errors++; $display("FAIL rr_rf_rd cycle %0d got %0d required %0d", i, rf_rd, exp_alu ? 10 : 11);
      end
      @(negedge clk);
    end
    ref_rf[10] = 32'hA10A_0010;
    ref_rf[11] = 32'hB11B_0011;
    set_alu(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if ({alu_wready, lsu_wready} !== 2'b01) begin errors++; $display("FAIL rr_lone_lsu got %b required 01", {alu_wready, lsu_wready}); end
    @(negedge clk);
    set_alu(1'b1, 5'd10, 32'hA10A_0010);
    #1;
    checks++; if ({alu_wready, lsu_wready} !== 2'b10) begin errors++; $display("FAIL rr_after_lone got %b required 10", {alu_wready, lsu_wready}); end
    @(negedge clk);
    idle();
    set_dec(1'b1, 5'd10, 5'd11, 5'd0, 1'b0);
    push_op(5'd10, 5'd11);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
  endtask

  // x0 writes are acknowledged without a write; x0 sources never stall
  task automatic test_x0();
    set_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    set_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++; if (alu_wready !== 1'b1) begin errors++; $display("FAIL x0_wready got %b required 1", alu_wready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_rf_wen got %b required 0", rf_wen); end
    checks++; if (rf_cs !== 1'b1) begin errors++; $display("FAIL x0_rf_cs got %b required 1", rf_cs); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_issue got %b required 1", dec_ready); end
    push_op(5'd0, 5'd0);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    set_dec(1'b1, 5'd0, 5'd10, 5'd12, 1'b1);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_b2b_issue got %b required 1", dec_ready); end
    push_op(5'd0, 5'd10);
    @(negedge clk);
    set_dec(1'b1, 5'd12, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL x12_busy got %b required 0", dec_ready); end
    set_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_never_stall got %b required 1", dec_ready); end
    push_op(5'd0, 5'd0);
    @(negedge clk);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_lsu(1'b1, 5'd12, 32'hC12C_0012);
    ref_rf[12] = 32'hC12C_0012;
    #1;
    checks++; if (lsu_wready !== 1'b1 || rf_wen !== 1'b1) begin errors++; $display("FAIL x12_write wready=%b wen=%b required 1 1", lsu_wready, rf_wen); end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
  endtask

  // Set wins over a same-cycle clear; a write to a non-busy register leaves it free
  task automatic test_set_wins();
    set_alu(1'b1, 5'd7, 32'h7777_0077);
    set_dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    ref_rf[7] = 32'h7777_0077;
    #1;
    checks++; if (dec_ready !== 1'b1 || alu_wready !== 1'b1) begin errors++; $display("FAIL sw_issue ready=%b wready=%b required 1 1", dec_ready, alu_wready); end
    push_op(5'd0, 5'd0);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    set_dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL sw_busy7 got %b required 0", dec_ready); end
    @(negedge clk);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_lsu(1'b1, 5'd7, 32'h7878_0078);
    ref_rf[7] = 32'h7878_0078;
    @(negedge clk);
    set_lsu(1'b0, 5'd0, 32'h0);
    set_alu(1'b1, 5'd9, 32'h9999_0099);
    ref_rf[9] = 32'h9999_0099;
    #1;
    checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9) begin errors++; $display("FAIL sw_nonbusy_write wen=%b rd=%0d required 1 9", rf_wen, rf_rd); end
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    set_dec(1'b1, 5'd7, 5'd9, 5'd0, 1'b0);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL sw_free_7_9 got %b required 1", dec_ready); end
    push_op(5'd7, 5'd9);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
  endtask

  // Reset in flight: pending operand and busy bit discarded, no write, ALU first after release
  task automatic test_reset_mid();
    set_dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    set_dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd4, 32'h4444_0044);
    set_lsu(1'b1, 5'd6, 32'h6666_0066);
    #1;
    exp_q.delete();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rm_op_valid got %b required 0", op_valid); end
    checks++; if (rf_wen !== 1'b0 || rf_cs !== 1'b0) begin errors++; $display("FAIL rm_no_write wen=%b cs=%b required 0 0", rf_wen, rf_cs); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rm_busy3_cleared got %b required 1", dec_ready); end
    repeat (2) @(negedge clk);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    rstn = 1'b1;
    #1;
    checks++; if ({alu_wready, lsu_wready} !== 2'b10) begin errors++; $display("FAIL rm_alu_first got %b required 10", {alu_wready, lsu_wready}); end
    @(negedge clk);
    #1;
    checks++; if ({alu_wready, lsu_wready} !== 2'b01) begin errors++; $display("FAIL rm_lsu_second got %b required 01", {alu_wready, lsu_wready}); end
    ref_rf[4] = 32'h4444_0044;
    ref_rf[6] = 32'h6666_0066;
    @(negedge clk);
    idle();
    set_dec(1'b1, 5'd4, 5'd6, 5'd0, 1'b0);
    push_op(5'd4, 5'd6);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]    = (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
      ref_rf[i] = mem[i];
    end
    rf_a = 32'h0;
    rf_b = 32'h0;
    idle();
    test_reset();
    test_dependency();
    test_arbitration();
    test_x0();
    test_set_wins();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL op_missing got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_rf_sched.md
RISCV_RF_SCHED -- requirements
Module: riscv_rf_sched

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, register data width.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 dec_valid  input  1  decode requests operand read/issue.
REQ-005 dec_rs1, dec_rs2, dec_rd  input  5 each  source and destination register indices.
REQ-006 dec_wb  input  1  the instruction writes dec_rd.
REQ-007 dec_ready  output  1  issue permitted this cycle.
REQ-008 alu_wvalid, lsu_wvalid  input  1 each  writeback requests.
REQ-009 alu_wrd, lsu_wrd  input  5 each  writeback destination indices.
REQ-010 alu_wdata, lsu_wdata  input  XLEN each  writeback data.
REQ-011 alu_wready, lsu_wready  output  1 each  writeback grant; at most one SHALL be high per cycle.
REQ-012 rf_cs, rf_wen  output  1 each  register-file enable and write enable.
REQ-013 rf_ra, rf_rb, rf_rd  output  5 each  register-file read A, read B and write addresses.
REQ-014 rf_data  output  XLEN  register-file write data.
REQ-015 rf_a, rf_b  input  XLEN each  register-file read data, valid one cycle after rf_cs.
REQ-016 op_valid  output  1  operands valid; op_a, op_b  output  XLEN each  issued operands.

Function
REQ-017 A 32-bit scoreboard SHALL hold busy[i] for each register i; busy[0] SHALL always read 0.
REQ-018 dec_ready SHALL be !busy[dec_rs1] & !busy[dec_rs2] & !(dec_wb & busy[dec_rd]), using registered busy bits, and SHALL NOT depend on dec_valid.
REQ-019 Issue SHALL occur when dec_valid & dec_ready; at the next clock edge, busy[dec_rd] SHALL be set if dec_wb and dec_rd != 0.
REQ-020 Writeback arbitration SHALL be round-robin: a single requester is granted immediately; when both request, the requester indicated by the priority pointer is granted.
REQ-021 After each cycle in which both requesters request, the priority pointer SHALL toggle to the requester that was not granted; otherwise it SHALL hold.
REQ-022 On a grant, rf_wen SHALL be 1 if the granted rd != 0; otherwise rf_wen SHALL be 0 and the request SHALL still be acknowledged. rf_rd and rf_data SHALL carry the granted rd and data.
REQ-023 At the edge following a grant, busy[granted rd] SHALL clear; if issue sets the same index in the same cycle, set SHALL win.
REQ-024 A grant to a non-busy register SHALL still write; busy SHALL remain 0.
REQ-025 rf_cs SHALL be issue | grant; rf_ra = dec_rs1 and rf_rb = dec_rs2 at all times.
REQ-026 op_valid SHALL be issue registered by one cycle; op_a/op_b SHALL be rf_a/rf_b, or the bypass value per REQ-031.
REQ-027 Without bypass, a register written in grant cycle N SHALL be issuable at the earliest in cycle N+1.

Reset
REQ-028 Assertion of rstn SHALL immediately clear busy[31:0] and op_valid, set the priority pointer to ALU, and force rf_cs=0 and rf_wen=0; outputs SHALL remain so until rstn deasserts.
REQ-029 Reset mid-operation SHALL discard in-flight writebacks and pending operands; no write SHALL occur in the cycle reset is asserted.

Configuration
REQ-030 Macro RF_SCHED_BYPASS_EN SHALL compile in same-cycle write forwarding; when undefined, REQ-027 applies.
REQ-031 With RF_SCHED_BYPASS_EN defined, dec_ready SHALL treat a busy register as free when it equals the granted rd (rd != 0) this cycle. A source matching that rd SHALL be registered with a select bit, and op_a/op_b SHALL then output the registered granted write data instead of rf_a/rf_b.

Verification
REQ-032 Issue rd=5 (dec_wb=1), then issue rs1=5 -> dec_ready=0 until the ALU writes x5; without bypass, issue is allowed the cycle after the grant; with bypass, in the grant cycle, with op_a equal to the written data.
REQ-033 alu_wvalid and lsu_wvalid held high for 4 cycles after reset -> grants alternate ALU, LSU, ALU, LSU.
REQ-034 Write to rd=0 with data 0xDEADBEEF -> wready=1, rf_wen=0; issue with rs1=0 is never stalled.
REQ-035 Write x7 granted in the same cycle as issue with rd=7 (bypass build) -> busy[7]=1 afterward.
REQ-036 rstn asserted while busy[3]=1 and both wvalid high -> busy cleared, no rf_wen, op_valid=0; after release, the ALU is granted first.
